fb_write_sequencer: RTL



---
 rtl/fb_write_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fb_write_sequencer.sv
// Framebuffer write sequencer: grants write sources 0..MAX_WRITE_SOURCE in turn once per frame
// and streams their pixels into the back-buffer bank. Optional GRANT watchdog: FB_SEQ_TIMEOUT_EN.
module fb_write_sequencer #(
  parameter int MAX_WRITE_SOURCE = 2,
  parameter int COLOR_DEPTH      = 9,
  parameter int SCREEN_W         = 640,
  parameter int SCREEN_H         = 480,
  parameter int TIMEOUT_CYCLES   = 1024,
  localparam int SOURCE_SEL_ADDRW = (MAX_WRITE_SOURCE > 0) ? $clog2(MAX_WRITE_SOURCE + 1) : 1,
  localparam int ADDRW            = $clog2(SCREEN_W * SCREEN_H)
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        frame,
  input  logic [COLOR_DEPTH-1:0]      write_color_data,
  input  logic                        write_transparent,
  input  logic [31:0]                 write_x_addr,
  input  logic [31:0]                 write_y_addr,
  input  logic                        write_active,
  output logic                        write_awaited,
  output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
  output logic                        mem_we,
  output logic [ADDRW-1:0]            mem_addr,
  output logic [COLOR_DEPTH-1:0]      mem_data,
  output logic                        mem_bank,
  output logic                        overrun
);

  typedef enum logic [1:0] {IDLE, GRANT, STREAM, NEXT} state_t;

  localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_SRC = SOURCE_SEL_ADDRW'(MAX_WRITE_SOURCE);

  state_t state;
  logic   pixel_take;
  logic   pixel_keep;

  assign pixel_take = write_active && ((state == GRANT) || (state == STREAM));
  assign pixel_keep = !write_transparent &&
                      (write_x_addr < 32'(SCREEN_W)) &&
                      (write_y_addr < 32'(SCREEN_H));

`ifdef FB_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] grant_cycles;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state            <= IDLE;
      write_source_sel <= '0;
      write_awaited    <= 1'b0;
      mem_bank         <= 1'b0;
      overrun          <= 1'b0;
`ifdef FB_SEQ_TIMEOUT_EN
      grant_cycles     <= '0;
`endif
    end else begin
      // A frame pulse outside IDLE (including the NEXT->IDLE cycle) is only flagged.
      if (frame && (state != IDLE))
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame) begin
            mem_bank         <= ~mem_bank;
            write_source_sel <= '0;
            write_awaited    <= 1'b1;
            state            <= GRANT;
`ifdef FB_SEQ_TIMEOUT_EN
            grant_cycles     <= '0;
`endif
          end
        end
        GRANT: begin
          if (write_active) begin
            state <= STREAM;
          end
`ifdef FB_SEQ_TIMEOUT_EN
          else if (grant_cycles == TW'(TIMEOUT_CYCLES - 1)) begin
            state         <= NEXT;
            write_awaited <= 1'b0;
          end else begin
            grant_cycles <= grant_cycles + 1'b1;
          end
`endif
        end
        STREAM: begin
          if (!write_active) begin
            state         <= NEXT;
            write_awaited <= 1'b0;
          end
        end
        NEXT: begin
          if (write_source_sel == LAST_SRC) begin
            state <= IDLE;
          end else begin
            write_source_sel <= write_source_sel + 1'b1;
            write_awaited    <= 1'b1;
            state            <= GRANT;
`ifdef FB_SEQ_TIMEOUT_EN
            grant_cycles     <= '0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address is formed at 32 bits; only the low ADDRW bits reach the memory.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      mem_we <= pixel_take && pixel_keep;
      if (pixel_take && pixel_keep) begin
        mem_addr <= ADDRW'(write_y_addr * 32'(SCREEN_W) + write_x_addr);
        mem_data <= write_color_data;
      end
    end
  end

endmodule
